// File: rtl/da_accumulator.sv
// Distributed-arithmetic accumulator: eight programmable partial-coefficient LUTs, adder tree
// and shift-accumulator over DATA_W bit-planes. Define DA_SAT_ROUND_EN for round + saturate output.
module da_accumulator #(
   parameter int COEF_W    = 16,
   parameter int DATA_W    = 16,
   parameter int OUT_W     = COEF_W + 3 + DATA_W,
   parameter int RND_SHIFT = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              plane_valid,
   input  logic              plane_first,
   input  logic [7:0]        A0,
   input  logic [7:0]        A1,
   input  logic [7:0]        A2,
   input  logic [7:0]        A3,
   input  logic [7:0]        A4,
   input  logic [7:0]        A5,
   input  logic [7:0]        A6,
   input  logic [7:0]        A7,
   input  logic              lut_we,
   input  logic [2:0]        lut_sel,
   input  logic [7:0]        lut_addr,
   input  logic [COEF_W-1:0] lut_wdata,
   output logic [OUT_W-1:0]  y,
   output logic              y_valid,
   output logic              overrun
);

   localparam int SUM_W = COEF_W + 3;
   localparam int ACC_W = SUM_W + DATA_W;
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t                    state, state_nx;
   logic [CNT_W-1:0]          cnt, cnt_nx;
   logic                      accept, last, reject;
   logic [7:0]                addr [8];
   logic signed [COEF_W-1:0]  lut [8][256];
   logic signed [COEF_W-1:0]  s1_ent [8];
   logic                      s1_valid, s1_first, s1_last;
   logic signed [SUM_W-1:0]   sum, s2_sum;
   logic                      s2_valid, s2_first, s2_last;
   logic signed [ACC_W-1:0]   acc, acc_next;
   logic [OUT_W-1:0]          y_next;

   assign addr = '{A0, A1, A2, A3, A4, A5, A6, A7};

   // Plane counter: only a plane_first may start a word; a stray plane outside ACC is rejected.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      last     = 1'b0;
      reject   = 1'b0;
      if (plane_valid) begin
         if (plane_first) begin
            accept = 1'b1;
            cnt_nx = CNT_W'(1);
         end else if (state == ACC) begin
            accept = 1'b1;
            cnt_nx = cnt + 1'b1;
         end else begin
            reject = 1'b1;
         end
         if (accept) begin
            last     = (cnt_nx == CNT_W'(DATA_W));
            state_nx = last ? DONE : ACC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         overrun <= reject;
      end
   end

   // NOTE: LUT storage has no reset; contents are software-loaded and a reset port would block RAM mapping.
   always_ff @(posedge clk) begin
      if (lut_we)
         lut[lut_sel][lut_addr] <= lut_wdata;
   end

   // Stage 1: registered LUT read, so a same-cycle write to the read address returns the old entry.
   always_ff @(posedge clk) begin
      if (accept)
         for (int k = 0; k < 8; k++)
            s1_ent[k] <= lut[k][addr[k]];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s2_valid <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
      end else begin
         s1_valid <= accept;
         s1_first <= plane_first;
         s1_last  <= last;
         s2_valid <= s1_valid;
         s2_first <= s1_first;
         s2_last  <= s1_last;
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < 8; k++)
         sum = sum + SUM_W'(s1_ent[k]);
   end

   always_ff @(posedge clk) begin
      if (s1_valid)
         s2_sum <= sum;
   end

   // The MSB plane carries negative weight in two's complement, hence acc = -S on the first plane.
   assign acc_next = s2_first ? -ACC_W'(s2_sum) : (acc <<< 1) + ACC_W'(s2_sum);

`ifdef DA_SAT_ROUND_EN
   localparam int EXT_W = ACC_W + OUT_W + 2;
   localparam logic signed [EXT_W-1:0] RND_ADD = (EXT_W'(1) << RND_SHIFT) >> 1;
   localparam logic signed [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
   localparam logic signed [EXT_W-1:0] SAT_MIN = -(EXT_W'(1) << (OUT_W - 1));

   logic signed [EXT_W-1:0] acc_ext, y_ext;

   always_comb begin
      acc_ext = EXT_W'(acc_next) + RND_ADD;
      y_ext   = acc_ext >>> RND_SHIFT;
      if (y_ext > SAT_MAX)
         y_next = OUT_W'(SAT_MAX);
      else if (y_ext < SAT_MIN)
         y_next = OUT_W'(SAT_MIN);
      else
         y_next = OUT_W'(y_ext);
   end
`else
   assign y_next = OUT_W'(acc_next >>> RND_SHIFT);
`endif

   // Stage 3: the result is taken from acc_next so y lands on the same edge as the final accumulate.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc     <= '0;
         y       <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= 1'b0;
         if (s2_valid) begin
            acc <= acc_next;
            if (s2_last) begin
               y       <= y_next;
               y_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_da_accumulator.sv
// Self-checking bench for da_accumulator: directed vector table, multi-cycle corner sequences,
// and random words against a plain FIR dot-product model; a second instance covers the output stage.
module tb_da_accumulator;

   logic               clk = 1'b0;
   logic               resetn;
   logic               plane_valid, plane_first;
   logic [7:0]         A0, A1, A2, A3, A4, A5, A6, A7;
   logic               lut_we, lut_we2;
   logic [2:0]         lut_sel;
   logic [7:0]         lut_addr;
   logic [15:0]        lut_wdata;
   logic signed [34:0] y;
   logic               y_valid, overrun;
   logic signed [7:0]  y2;
   logic               y_valid2, overrun2;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int vcount   = 0;
   int t_first  = 0;
   bit rnd_on   = 1'b0;

   logic signed [15:0] xw [64];
   int                 coef [64];
   longint             exp_q [$];

   typedef struct {
      string              name;
      logic signed [15:0] xval;
      int                 pre_planes;
      int                 gap_at;
      int                 gap_len;
      longint             exp_y;
      int                 exp_delta;
   } vec_t;

   typedef struct {
      int     c;
      longint exp_y;
   } out_vec_t;

   vec_t     vecs [7];
   out_vec_t ovecs [4];

   da_accumulator dut (
      .clk(clk), .resetn(resetn), .plane_valid(plane_valid), .plane_first(plane_first),
      .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7),
      .lut_we(lut_we), .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
      .y(y), .y_valid(y_valid), .overrun(overrun)
   );

   da_accumulator #(.OUT_W(8), .RND_SHIFT(2)) dut2 (
      .clk(clk), .resetn(resetn), .plane_valid(plane_valid), .plane_first(plane_first),
      .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7),
      .lut_we(lut_we2), .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
      .y(y2), .y_valid(y_valid2), .overrun(overrun2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (y_valid) vcount <= vcount + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rnd_on && y_valid) begin
         check("rnd y_valid with a pending word", longint'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) check("rnd y", y, exp_q.pop_front());
      end
   end

   function automatic logic [63:0] plane_of(input int p);
      logic [63:0] b;
      for (int t = 0; t < 64; t++) b[t] = xw[t][15 - p];
      return b;
   endfunction

   task automatic fill(input logic signed [15:0] v);
      for (int t = 0; t < 64; t++) xw[t] = v;
   endtask

   task automatic drive_plane(input logic first, input logic [63:0] b);
      plane_valid = 1'b1;
      plane_first = first;
      {A7, A6, A5, A4, A3, A2, A1, A0} = b;
      @(negedge clk);
      plane_valid = 1'b0;
      plane_first = 1'b0;
   endtask

   task automatic send_word(input int n_planes, input int gap_at, input int gap_len);
      for (int p = 0; p < n_planes; p++) begin
         if (p == gap_at) repeat (gap_len) @(negedge clk);
         drive_plane(p == 0, plane_of(p));
         if (p == 0) t_first = cyc;
      end
   endtask

   task automatic wait_valid(input string name);
      for (int k = 0; k < 12 && y_valid !== 1'b1; k++) @(negedge clk);
      check({name, " y_valid seen"}, y_valid, 1);
   endtask

   task automatic lut_write(input bit second, input logic [2:0] sel, input logic [7:0] a,
                            input logic [15:0] d);
      lut_sel   = sel;
      lut_addr  = a;
      lut_wdata = d;
      lut_we    = ~second;
      lut_we2   = second;
      @(negedge clk);
      lut_we    = 1'b0;
      lut_we2   = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int v0;
      longint e;

      vecs[0] = '{"x=+1",    16'sd1,      0, -1, 0, 64,       17};
      vecs[1] = '{"x=-1",    -16'sd1,     0, -1, 0, -64,      17};
      vecs[2] = '{"x=+3",    16'sd3,      0, -1, 0, 192,      17};
      vecs[3] = '{"x=min",   16'sh8000,   0, -1, 0, -2097152, 17};
      vecs[4] = '{"x=max",   16'sh7FFF,   0, -1, 0, 2097088,  17};
      vecs[5] = '{"gap3",    16'sd1,      0,  7, 3, 64,       20};
      vecs[6] = '{"abort",   16'sd1,      8, -1, 0, 64,       17};
`ifdef DA_SAT_ROUND_EN
      ovecs[0] = '{1000, 127};
      ovecs[1] = '{10, 3};
      ovecs[2] = '{-1000, -128};
      ovecs[3] = '{-10, -2};
`else
      ovecs[0] = '{1000, -6};
      ovecs[1] = '{10, 2};
      ovecs[2] = '{-1000, 6};
      ovecs[3] = '{-10, -3};
`endif

      resetn = 1'b0; plane_valid = 1'b0; plane_first = 1'b0;
      {A7, A6, A5, A4, A3, A2, A1, A0} = '0;
      lut_we = 1'b0; lut_we2 = 1'b0; lut_sel = '0; lut_addr = '0; lut_wdata = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("reset y", y, 0);
      check("reset y_valid", y_valid, 0);
      check("reset overrun", overrun, 0);

      for (int k = 0; k < 8; k++)
         for (int a = 0; a < 256; a++)
            lut_write(1'b0, 3'(k), 8'(a), 16'($countones(8'(a))));

      for (int i = 0; i < 7; i++) begin
         v0 = vcount;
         if (vecs[i].pre_planes > 0) begin
            fill(16'sd5);
            send_word(vecs[i].pre_planes, -1, 0);
         end
         fill(vecs[i].xval);
         send_word(16, vecs[i].gap_at, vecs[i].gap_len);
         wait_valid(vecs[i].name);
         check({vecs[i].name, " latency"}, cyc - t_first, vecs[i].exp_delta);
         check({vecs[i].name, " y"}, y, vecs[i].exp_y);
         @(negedge clk);
         check({vecs[i].name, " pulse width"}, y_valid, 0);
         repeat (2) @(negedge clk);
         check({vecs[i].name, " pulse count"}, vcount - v0, 1);
      end

      // Write to LUT0[FF] in the same cycle the last plane reads it: old entry expected.
      fill(16'sd1);
      send_word(15, -1, 0);
      lut_sel = 3'd0; lut_addr = 8'hFF; lut_wdata = 16'd100; lut_we = 1'b1;
      drive_plane(1'b0, plane_of(15));
      lut_we = 1'b0;
      wait_valid("rdw");
      check("rdw old entry y", y, 64);
      repeat (2) @(negedge clk);
      send_word(16, -1, 0);
      wait_valid("rdw next");
      check("rdw new entry y", y, 156);
      lut_write(1'b0, 3'd0, 8'hFF, 16'd8);
      repeat (2) @(negedge clk);

      // 17th plane without plane_first.
      send_word(16, -1, 0);
      wait_valid("ovr word");
      check("ovr word y", y, 64);
      repeat (3) @(negedge clk);
      v0 = vcount;
      drive_plane(1'b0, '1);
      check("ovr pulse", overrun, 1);
      @(negedge clk);
      check("ovr one cycle", overrun, 0);
      repeat (4) @(negedge clk);
      check("ovr no y_valid", vcount - v0, 0);
      check("ovr y held", y, 64);

      // Reset right after the last plane: word in flight is dropped.
      v0 = vcount;
      fill(16'sd1);
      send_word(16, -1, 0);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      check("rst mid no y_valid", vcount - v0, 0);
      check("rst mid y cleared", y, 0);
      drive_plane(1'b0, '1);
      check("idle stray overrun", overrun, 1);
      @(negedge clk);

      // Random words against y = sum of x_t * c_t with linear LUTs built from random coefficients.
      for (int t = 0; t < 64; t++) coef[t] = int'($urandom_range(0, 8190)) - 4095;
      for (int k = 0; k < 8; k++)
         for (int a = 0; a < 256; a++) begin
            int val;
            val = 0;
            for (int i = 0; i < 8; i++) if (a[i]) val += coef[8 * k + i];
            lut_write(1'b0, 3'(k), 8'(a), 16'(val));
         end
      rnd_on = 1'b1;
      for (int w = 0; w < 40; w++) begin
         if ($urandom_range(0, 5) == 0) begin
            for (int t = 0; t < 64; t++) xw[t] = 16'($urandom);
            send_word(int'($urandom_range(1, 15)), -1, 0);
         end
         for (int t = 0; t < 64; t++) xw[t] = 16'($urandom);
         e = 0;
         for (int t = 0; t < 64; t++) e += longint'(xw[t]) * longint'(coef[t]);
         exp_q.push_back(e);
         send_word(16, int'($urandom_range(1, 15)), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
      check("rnd drain", exp_q.size(), 0);
      rnd_on = 1'b0;

      // Output stage (OUT_W=8, RND_SHIFT=2): only tap 0 = 1, so acc_final = LUT0[1].
      for (int k = 0; k < 8; k++) lut_write(1'b1, 3'(k), 8'h00, 16'd0);
      fill(16'sd0);
      xw[0] = 16'sd1;
      for (int i = 0; i < 4; i++) begin
         lut_write(1'b1, 3'd0, 8'h01, 16'(ovecs[i].c));
         send_word(16, -1, 0);
         repeat (2) @(negedge clk);
         check($sformatf("out acc=%0d y_valid", ovecs[i].c), y_valid2, 1);
         check($sformatf("out acc=%0d y", ovecs[i].c), y2, ovecs[i].exp_y);
         check($sformatf("out acc=%0d overrun", ovecs[i].c), overrun2, 0);
         repeat (2) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
